// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/register block and the RX FIFO.
// The master drives characters and control, the slave is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [15:0]      shift_div_i;
    logic             wr_valid_i;
    logic [7:0]       wr_data_i;
    logic             wr_frame_err_i;
    logic             rd_pop_i;
    logic             flush_i;
    logic             overrun_clr_i;
    logic [PTR_W:0]   threshold_i;
    logic [7:0]       rd_data_o;
    logic             rd_frame_err_o;
    logic             empty_o;
    logic             full_o;
    logic [PTR_W:0]   level_o;
    logic             overrun_o;
    logic             thresh_o;
    logic             timeout_o;

    modport master (
        output shift_div_i,
        output wr_valid_i,
        output wr_data_i,
        output wr_frame_err_i,
        output rd_pop_i,
        output flush_i,
        output overrun_clr_i,
        output threshold_i,
        input  rd_data_o,
        input  rd_frame_err_o,
        input  empty_o,
        input  full_o,
        input  level_o,
        input  overrun_o,
        input  thresh_o,
        input  timeout_o
    );

    modport slave (
        input  shift_div_i,
        input  wr_valid_i,
        input  wr_data_i,
        input  wr_frame_err_i,
        input  rd_pop_i,
        input  flush_i,
        input  overrun_clr_i,
        input  threshold_i,
        output rd_data_o,
        output rd_frame_err_o,
        output empty_o,
        output full_o,
        output level_o,
        output overrun_o,
        output thresh_o,
        output timeout_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through character buffer with
// level, threshold, sticky overrun and character-timeout status.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    uart_rx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [5:0] IDLE_MAX = 6'd40;

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             overrun;
    logic [15:0]      presc;
    logic [5:0]       idle;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic drop;
    logic bit_tick;
    logic [8:0] head;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // A pop frees the slot the same cycle, so a full FIFO still accepts a
    // simultaneous push without losing the character.
    assign pop_ok  = bus.rd_pop_i & ~empty;
    assign push_ok = bus.wr_valid_i & (~full | pop_ok);
    assign drop    = bus.wr_valid_i & ~push_ok;

    assign bit_tick = (presc == 16'd0);

    always_ff @(posedge clock_i) begin
        if (push_ok && !bus.flush_i) begin
            mem[wr_ptr] <= {bus.wr_frame_err_i, bus.wr_data_i};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overrun: a new drop beats a coincident clear.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            overrun <= 1'b0;
        end else if (bus.flush_i) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (bus.overrun_clr_i) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            presc <= 16'd0;
        end else if (bit_tick) begin
            presc <= bus.shift_div_i;
        end else begin
            presc <= presc - 16'd1;
        end
    end

    // Idle time in bit periods since the last FIFO activity.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idle <= 6'd0;
        end else if (bus.flush_i || push_ok || pop_ok || empty) begin
            idle <= 6'd0;
        end else if (bit_tick && idle != IDLE_MAX) begin
            idle <= idle + 6'd1;
        end
    end

    assign head = empty ? 9'd0 : mem[rd_ptr];

    assign bus.rd_data_o      = head[7:0];
    assign bus.rd_frame_err_o = head[8];
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.level_o        = level;
    assign bus.overrun_o      = overrun;
    assign bus.thresh_o       = (bus.threshold_i != '0) &&
                                (level >= bus.threshold_i);
    assign bus.timeout_o      = (idle == IDLE_MAX);
endmodule
